rgmii_tx_clk_pattern_gen: RTL and testbench
===========================================

Name: rgmii_tx_clk_pattern_gen

Overview:
- Upstream feeder of the ODDR clock downsample/right-shift stage in the Ethernet controller's RGMII TX path.
- Runs on the 250 MHz TX clock and produces the 2-bit clock-setting word consumed every second cycle (on downstream ready), so the downstream stage emits a 2.5, 25 or 125 MHz RGMII TX clock.
- Emits one TX data strobe per generated clock period for the MAC/byte-to-nibble path.
- Applies runtime speed changes only on clock-period boundaries, so the generated clock never glitches.

Parameters:
- init_speed_p, 2'b10, speed in effect out of reset (encoding as speed_i).
- sync_stages_p, 2, synchroniser flop depth on speed_i (minimum 2).

Ports:
- clk_i  in  1  250 MHz TX clock.
- reset_n_i  in  1  asynchronous active-low reset.
- speed_i  in  2  requested link speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = treated as 1000M. Quasi-static, asynchronous to clk_i.
- ready_i  in  1  downstream accepts clk_setting_o on this posedge (asserted every second cycle).
- clk_setting_o  out  2  half-cycle pattern. Bit[0] is driven in the first 250 MHz cycle, bit[1] in the second.
- tx_strobe_o  out  1  one-cycle pulse, once per generated clock period.
- speed_o  out  2  speed currently applied; normalised, so 11 is reported as 10.
- mii_mode_o  out  1  1 when speed_o != 10 (nibble/SDR mode), 0 for DDR byte mode.

Behaviour:
- Asynchronous reset (reset_n_i = 0) drives: speed_r = init_speed_p normalised; phase_r = 0; tx_strobe_o = 0; synchroniser flops = init_speed_p.
- speed_i passes through a sync_stages_p-deep flop chain; the result is speed_s.
- Period length N in settings, by speed_r:
  - 1000M: N = 1.
  - 100M: N = 5.
  - 10M: N = 50.
- phase_r is 6 bits, range 0..N-1.
- Advance rule, evaluated on each posedge with ready_i = 1 (current word consumed):
  - If phase_r == N-1: phase_r <= 0 and speed_r <= normalised speed_s.
  - Otherwise: phase_r <= phase_r + 1.
- With ready_i = 0 all state holds and clk_setting_o is stable.
- clk_setting_o is a combinational decode of (speed_r, phase_r) with no added latency. Downstream captures it on the same edge the generator advances.
  - 1000M: always 2'b01 (high, low).
  - 100M: phases 0–1 = 2'b11; phase 2 = 2'b01; phases 3–4 = 2'b00. This gives 5 high / 5 low 250 MHz cycles.
  - 10M: phases 0–24 = 2'b11; phases 25–49 = 2'b00. This gives 50 high / 50 low.
- Duty cycle is exactly 50% at every speed. The first half-cycle of every period is high.
- tx_strobe_o <= ready_i & (phase_r == 0): registered, one cycle after the rising-edge word is consumed. It is never high on two consecutive cycles.
- speed_o = speed_r and mii_mode_o = (speed_r != 2'b10). Both are registered state, so they change only at period wrap.
- Speed change mid-period: the old pattern completes, and the new speed takes effect from the next phase 0. A change reverted before the wrap has no effect.
- phase_r out of range cannot occur under the speed_r update rule. The decode still outputs 2'b00 for any phase_r >= N as a safety default.
- Reset asserted mid-period: state returns to init immediately (asynchronous). After release, the first consumed word is the phase-0 word of init_speed_p.
- ready_i held high every cycle (protocol violation) still advances once per cycle. Consistent, but not a supported mode.

Test Plan:
- Reset with init_speed_p = 10, speed_i = 10, ready_i toggling 0/1 → clk_setting_o = 01 on every ready; tx_strobe_o pulses every 2 cycles; mii_mode_o = 0; the downstream-model clock output measures 8 ns period, 4 ns high.
- speed_i = 01 after reset → after the sync delay and current period wrap, the word sequence is 11,11,01,00,00 repeating; tx_strobe_o every 10 cycles; output clock 40 ns, 20 ns high; speed_o = 01.
- speed_i = 00 → 25×11 then 25×00 per period; tx_strobe_o every 100 cycles; output clock 400 ns, 200 ns high.
- Change speed_i 00→01 while phase_r = 10 at 10M → the remaining 10M period completes (phase reaches 49), then phase 0 of 100M; no high or low pulse shorter than 4 ns on the model output.
- Hold ready_i = 0 for 7 cycles mid-period → clk_setting_o, phase_r and tx_strobe_o frozen (strobe 0), then resume from the same phase.
- Assert reset_n_i mid-period at 100M (phase 3), with init_speed_p = 10 → outputs immediately reset (phase 0, speed_o = 10, strobe 0); after release, clk_setting_o = 01.

Source files
------------

// File: rtl/rgmii_tx_clk_pattern_gen.sv
// -----------------------------------------------------------------------------
// rgmii_tx_clk_pattern_gen
//
// Produces the 2-bit half-cycle clock-setting word for the ODDR clock
// downsample stage of the RGMII TX path. The downstream stage consumes one
// word every second 250 MHz cycle (ready_i). It emits bit[0] in the first
// cycle and bit[1] in the second. The result is a 125, 25 or 2.5 MHz RGMII
// TX clock with a 50% duty cycle. Speed changes are applied only at period
// boundaries, so the generated clock never glitches.
//
// Ports:
//   clk_i          250 MHz TX clock
//   reset_n_i      asynchronous active-low reset
//   speed_i        requested speed (00=10M, 01=100M, 10/11=1000M), async
//   ready_i        downstream consumes clk_setting_o on this posedge
//   clk_setting_o  half-cycle pattern for the current phase (combinational)
//   tx_strobe_o    one-cycle pulse per generated clock period
//   speed_o        applied speed, normalised (11 reported as 10)
//   mii_mode_o     1 for nibble/SDR modes (10M/100M), 0 for DDR byte mode
// -----------------------------------------------------------------------------
module rgmii_tx_clk_pattern_gen #(
  parameter logic [1:0] init_speed_p  = 2'b10,
  parameter int         sync_stages_p = 2      // must be at least 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] speed_i,
  input  logic       ready_i,
  output logic [1:0] clk_setting_o,
  output logic       tx_strobe_o,
  output logic [1:0] speed_o,
  output logic       mii_mode_o
);

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10
  } speed_e;

  // The 11 code is an alias of 1000M. It is folded here so that the state
  // only ever holds one of the three legal speeds.
  function automatic speed_e normalise(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1000M : speed_e'(s);
  endfunction

  logic [sync_stages_p-1:0][1:0] sync_q;
  logic [1:0]                    speed_s;
  speed_e                        speed_r;
  logic [5:0]                    phase_r;
  logic [5:0]                    last_phase;
  logic                          tx_strobe_r;

  // speed_i is quasi-static. A plain flop chain is enough because a changed
  // value is used only at a period wrap, long after it has settled.
  // NOTE: the synchroniser flops are reset to init_speed_p like ordinary
  // state. If they were left unreset, the first wrap could apply X/garbage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < sync_stages_p; i++) sync_q[i] <= init_speed_p;
    end else begin
      // NOTE: non-blocking assignments let each stage sample the previous
      // stage's old value. Blocking assignments here would collapse the chain.
      sync_q[0] <= speed_i;
      for (int i = 1; i < sync_stages_p; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign speed_s = sync_q[sync_stages_p-1];

  // Index of the last word in the current period (N-1).
  always_comb begin
    // NOTE: assign a default before the case, so that every path drives the
    // signal and no latch is inferred.
    last_phase = 6'd0;
    case (speed_r)
      SPEED_10M:   last_phase = 6'd49;
      SPEED_100M:  last_phase = 6'd4;
      SPEED_1000M: last_phase = 6'd0;
      default:     last_phase = 6'd0;
    endcase
  end

  // Word decode. In each period, the first N half-cycles are high and the
  // last N are low. Any phase outside the period decodes to 00.
  always_comb begin
    clk_setting_o = 2'b00;
    case (speed_r)
      SPEED_1000M: if (phase_r == 6'd0) clk_setting_o = 2'b01;
      SPEED_100M: begin
        if (phase_r <= 6'd1)      clk_setting_o = 2'b11;
        else if (phase_r == 6'd2) clk_setting_o = 2'b01;
      end
      SPEED_10M:   if (phase_r <= 6'd24) clk_setting_o = 2'b11;
      default:     clk_setting_o = 2'b00;
    endcase
  end

  // The phase advances only when a word is consumed. A new speed is loaded
  // only at the wrap, so a running period always completes at its own speed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      speed_r     <= normalise(init_speed_p);
      phase_r     <= 6'd0;
      tx_strobe_r <= 1'b0;
    end else begin
      tx_strobe_r <= ready_i && (phase_r == 6'd0);
      if (ready_i) begin
        if (phase_r == last_phase) begin
          phase_r <= 6'd0;
          speed_r <= normalise(speed_s);
        end else begin
          phase_r <= phase_r + 6'd1;
        end
      end
    end
  end

  assign tx_strobe_o = tx_strobe_r;
  assign speed_o     = speed_r;
  assign mii_mode_o  = (speed_r != SPEED_1000M);

endmodule

// File: tb/tb_rgmii_tx_clk_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_rgmii_tx_clk_pattern_gen
//
// The driver issues ready_i/speed_i once per cycle and pushes the expected
// response into a scoreboard queue. The expected response comes from a
// reference model: within a period of N words, half-cycle h (h = 2*word + bit)
// is high exactly when h < N. The synchroniser is modelled as a pure delay
// over the speed_i sample history. A separate monitor pops one entry at every
// negedge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_rgmii_tx_clk_pattern_gen;

  localparam logic [1:0] INIT_SPEED  = 2'b10;
  localparam int         SYNC_STAGES = 2;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic [1:0] speed_i;
  logic       ready_i;
  logic [1:0] clk_setting_o;
  logic       tx_strobe_o;
  logic [1:0] speed_o;
  logic       mii_mode_o;

  rgmii_tx_clk_pattern_gen #(
    .init_speed_p (INIT_SPEED),
    .sync_stages_p(SYNC_STAGES)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .speed_i      (speed_i),
    .ready_i      (ready_i),
    .clk_setting_o(clk_setting_o),
    .tx_strobe_o  (tx_strobe_o),
    .speed_o      (speed_o),
    .mii_mode_o   (mii_mode_o)
  );

  always #2 clk_i = ~clk_i;  // 250 MHz

  typedef struct {
    logic       ready;
    logic [1:0] word;
    logic [1:0] spd;
    logic       strobe_next;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] hist[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         active   = 1'b0;

  // reference model state: applied speed and word index within its period
  logic [1:0] m_speed;
  int         m_phase;

  exp_t       mon_e;
  logic       mon_exp_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] norm(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic int period_words(input logic [1:0] s);
    case (norm(s))
      2'b00:   return 50;
      2'b01:   return 5;
      default: return 1;
    endcase
  endfunction

  function automatic logic [1:0] ref_word(input logic [1:0] s, input int ph);
    logic [1:0] w;
    int n;
    n = period_words(s);
    for (int b = 0; b < 2; b++) w[b] = ((2 * ph + b) < n);
    return w;
  endfunction

  task automatic model_reset();
    m_speed = norm(INIT_SPEED);
    m_phase = 0;
    hist.delete();
  endtask

  // Drive one cycle of stimulus and push the expected DUT response.
  task automatic issue(input logic r, input logic [1:0] s);
    exp_t e;
    int   k;
    ready_i = r;
    speed_i = s;
    hist.push_back(s);
    k = hist.size() - 1;
    e.ready       = r;
    e.word        = ref_word(m_speed, m_phase);
    e.spd         = m_speed;
    e.strobe_next = r && (m_phase == 0);
    if (r) begin
      if (m_phase == period_words(m_speed) - 1) begin
        m_phase = 0;
        m_speed = (k >= SYNC_STAGES) ? norm(hist[k - SYNC_STAGES]) : norm(INIT_SPEED);
      end else begin
        m_phase++;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: samples at the negedge, midway between driver updates and edges.
  initial begin
    forever begin
      @(negedge clk_i);
      if (active) begin
        check("tx_strobe", tx_strobe_o, mon_exp_strobe);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (mon_e.ready) check("clk_setting", clk_setting_o, mon_e.word);
          check("speed_o", speed_o, mon_e.spd);
          check("mii_mode", mii_mode_o, mon_e.spd != 2'b10);
          mon_exp_strobe = mon_e.strobe_next;
        end
      end else begin
        mon_exp_strobe = 1'b0;
      end
    end
  end

  // One test phase: reset, then n_cycles of stimulus. change_at switches
  // speed_i from spd0 to spd1. stall_at forces a 7-cycle ready_i stall.
  // rnd adds random stalls, bursts and speed changes. reset_at asserts reset
  // mid-phase and ends the phase.
  task automatic run_phase(input int n_cycles, input logic [1:0] spd0,
                           input int change_at, input logic [1:0] spd1,
                           input int stall_at, input bit rnd, input int reset_at);
    logic       r;
    logic       last_r;
    logic [1:0] cur_spd;
    int         stall;
    int         burst;
    stall   = 0;
    burst   = 0;
    last_r  = 1'b0;
    cur_spd = spd0;
    reset_n_i = 1'b0;
    ready_i   = 1'b0;
    speed_i   = spd0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_clk_setting", clk_setting_o, 2'b01);
    check("rst_speed_o", speed_o, norm(INIT_SPEED));
    check("rst_mii_mode", mii_mode_o, 1'b0);
    check("rst_strobe", tx_strobe_o, 1'b0);
    reset_n_i = 1'b1;
    model_reset();
    active = 1'b1;
    for (int c = 0; c < n_cycles; c++) begin
      if (c > 0) begin
        @(posedge clk_i);
        #1;
      end
      if (c == reset_at) begin
        active    = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check("midrst_clk_setting", clk_setting_o, 2'b01);
        check("midrst_speed_o", speed_o, norm(INIT_SPEED));
        check("midrst_strobe", tx_strobe_o, 1'b0);
        exp_q.delete();
        return;
      end
      if (c == stall_at) stall = 7;
      if (c == change_at) cur_spd = spd1;
      if (rnd && $urandom_range(0, 299) == 0) cur_spd = 2'($urandom_range(0, 3));
      if (stall > 0) begin
        r = 1'b0;
        stall--;
      end else if (burst > 0) begin
        r = 1'b1;
        burst--;
      end else if (rnd && $urandom_range(0, 39) == 0) begin
        stall = $urandom_range(0, 7);
        r = 1'b0;
      end else if (rnd && $urandom_range(0, 199) == 0) begin
        burst = $urandom_range(0, 3);
        r = 1'b1;
      end else begin
        r = ~last_r;
      end
      last_r = r;
      issue(r, cur_spd);
    end
    @(negedge clk_i);
    #1;
    active  = 1'b0;
    ready_i = 1'b0;
  endtask

  initial begin
    #(400_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i = 1'b0;
    ready_i   = 1'b0;
    speed_i   = INIT_SPEED;
    run_phase(60,   2'b10, -1,  2'b10, -1,  1'b0, -1);  // 1000M steady
    run_phase(300,  2'b01, -1,  2'b01, 123, 1'b0, -1);  // 100M with a 7-cycle stall
    run_phase(900,  2'b00, -1,  2'b00, 257, 1'b0, -1);  // 10M with a stall
    run_phase(500,  2'b00, 120, 2'b01, -1,  1'b0, -1);  // 10M -> 100M mid-period
    run_phase(200,  2'b11, 40,  2'b00, -1,  1'b0, -1);  // 11 alias, then 10M
    run_phase(4000, 2'b10, -1,  2'b10, -1,  1'b1, -1);  // randomized
    run_phase(200,  2'b01, -1,  2'b01, -1,  1'b0, 37);  // reset mid-period at 100M
    run_phase(40,   2'b10, -1,  2'b10, -1,  1'b0, -1);  // recovery after reset
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
